fifo_stream_reader: RTL and testbench

- Read-side controller for the 8-bit x 16-deep synchronous FIFO.
- Drives the FIFO's rd_en and absorbs its one-cycle registered read latency.
- Presents FIFO contents, in order, on a valid/ready output stream. An internal skid buffer ensures no word is lost or duplicated under backpressure.
- Sits between the FIFO read port and any downstream consumer, such as a serializer or DMA sink.

---
 rtl/fifo_stream_reader.sv | 117 +++++++++++
 tb/tb_fifo_stream_reader.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side controller for a synchronous FIFO: issues rd_en, absorbs the one-cycle read latency
// through a skid buffer and presents words on a valid/ready stream. Optional FIFO_RD_CHECKSUM_EN adds a checksum port.
module fifo_stream_reader #(
    parameter int DATA_W        = 8,
    parameter int SKID_DEPTH    = 4,
    parameter int START_ON_FULL = 1,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic              fifo_full,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    input  logic              flush,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              busy,
    output logic [CNT_W-1:0]  rd_count
`ifdef FIFO_RD_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int OCC_W = $clog2(SKID_DEPTH + 1) + 1;
    localparam bit AUTO_START = (START_ON_FULL == 0);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t             state;
    logic               vld_p1;
    logic [OCC_W-1:0]   buf_cnt;
    logic [OCC_W-1:0]   occ;
    logic [OCC_W-1:0]   cnt_after_pop;
    logic [OCC_W-1:0]   buf_cnt_nxt;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [DATA_W-1:0]  mem [SKID_DEPTH];
    logic               cap;
    logic               pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Reads in flight count against capacity so a late-arriving word always has a slot.
    assign occ           = buf_cnt + OCC_W'(vld_p1);
    assign cap           = vld_p1;
    assign pop           = m_valid && m_ready;
    assign cnt_after_pop = buf_cnt - OCC_W'(pop);
    assign buf_cnt_nxt   = cnt_after_pop + OCC_W'(cap);

    assign fifo_rd_en = rst && (state == DRAIN) && !fifo_empty && (occ < OCC_W'(SKID_DEPTH));
    assign busy       = (state != IDLE) || (buf_cnt != '0) || vld_p1;

    // Stage p0 -> p1: read issue and drain control
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            vld_p1   <= 1'b0;
            buf_cnt  <= '0;
            head     <= '0;
            tail     <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            rd_count <= '0;
`ifdef FIFO_RD_CHECKSUM_EN
            checksum <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if ((fifo_full || flush || AUTO_START) && !fifo_empty)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (fifo_empty && !flush && !AUTO_START)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            vld_p1  <= fifo_rd_en;
            buf_cnt <= buf_cnt_nxt;
            m_valid <= (buf_cnt_nxt != '0);

            if (cap)
                tail <= ptr_inc(tail);

            if (pop) begin
                head     <= ptr_inc(head);
                rd_count <= rd_count + CNT_W'(1);
`ifdef FIFO_RD_CHECKSUM_EN
                checksum <= checksum + m_data;
`endif
            end

            // Stage p1 -> p2: the output register always mirrors the buffer head
            if (cap && (cnt_after_pop == '0))
                m_data <= fifo_data;
            else if (pop && (buf_cnt > OCC_W'(1)))
                m_data <= mem[ptr_inc(head)];
        end
    end

    always_ff @(posedge clk) begin
        if (cap)
            mem[tail] <= fifo_data;
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: one instance with START_ON_FULL=1 and one with
// START_ON_FULL=0, each fed by a small behavioural 16-deep FIFO with registered read data.
module tb_fifo_stream_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic clr;

    logic       a_empty, a_full, a_rd_en, a_flush, a_valid, a_ready, a_busy, a_wr;
    logic [7:0] a_fdata, a_data, a_wdata, a_tmp;
    logic [15:0] a_count;
    logic [7:0] a_q[$];
    logic [7:0] a_out[$];
    int         a_uf = 0;

    logic       b_empty, b_full, b_rd_en, b_flush, b_valid, b_ready, b_busy, b_wr;
    logic [7:0] b_fdata, b_data, b_wdata, b_tmp;
    logic [15:0] b_count;
    logic [7:0] b_q[$];
    logic [7:0] b_out[$];
    int         b_uf = 0;

`ifdef FIFO_RD_CHECKSUM_EN
    logic [7:0] a_sum, b_sum;
`endif

    fifo_stream_reader #(.DATA_W(8), .SKID_DEPTH(4), .START_ON_FULL(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .fifo_empty(a_empty), .fifo_full(a_full), .fifo_data(a_fdata),
        .fifo_rd_en(a_rd_en), .flush(a_flush), .m_valid(a_valid), .m_ready(a_ready),
        .m_data(a_data), .busy(a_busy), .rd_count(a_count)
`ifdef FIFO_RD_CHECKSUM_EN
        , .checksum(a_sum)
`endif
    );

    fifo_stream_reader #(.DATA_W(8), .SKID_DEPTH(4), .START_ON_FULL(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .fifo_empty(b_empty), .fifo_full(b_full), .fifo_data(b_fdata),
        .fifo_rd_en(b_rd_en), .flush(b_flush), .m_valid(b_valid), .m_ready(b_ready),
        .m_data(b_data), .busy(b_busy), .rd_count(b_count)
`ifdef FIFO_RD_CHECKSUM_EN
        , .checksum(b_sum)
`endif
    );

    // Behavioural FIFOs plus output monitors
    always @(posedge clk) begin
        if (clr) a_q.delete();
        if (a_rd_en && a_empty) a_uf++;
        if (a_rd_en && a_q.size() != 0) begin
            a_tmp = a_q.pop_front();
            a_fdata <= a_tmp;
        end
        if (a_wr) a_q.push_back(a_wdata);
        a_empty <= (a_q.size() == 0);
        a_full  <= (a_q.size() == 16);
        if (!rst) a_out.delete();
        else if (a_valid && a_ready) a_out.push_back(a_data);
    end

    always @(posedge clk) begin
        if (clr) b_q.delete();
        if (b_rd_en && b_empty) b_uf++;
        if (b_rd_en && b_q.size() != 0) begin
            b_tmp = b_q.pop_front();
            b_fdata <= b_tmp;
        end
        if (b_wr) b_q.push_back(b_wdata);
        b_empty <= (b_q.size() == 0);
        b_full  <= (b_q.size() == 16);
        if (!rst) b_out.delete();
        else if (b_valid && b_ready) b_out.push_back(b_data);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        rst = 1'b0; clr = 1'b1;
        a_wr = 1'b0; b_wr = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
        a_flush = 1'b0; b_flush = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1; clr = 1'b0;
    endtask

    task automatic write_a(input int n, input logic [7:0] v0);
        for (int i = 0; i < n; i++) begin
            a_wr = 1'b1;
            a_wdata = v0 + 8'(i);
            next_cycle();
        end
        a_wr = 1'b0;
    endtask

    task automatic write_b(input int n, input logic [7:0] v0);
        for (int i = 0; i < n; i++) begin
            b_wr = 1'b1;
            b_wdata = v0 + 8'(i);
            next_cycle();
        end
        b_wr = 1'b0;
    endtask

    task automatic check_seq_a(input string name, input int n, input logic [7:0] v0);
        chk({name, "_len"}, 32'(a_out.size()), 32'(n));
        if (a_out.size() == n)
            for (int i = 0; i < n; i++)
                chk({name, "_word"}, 32'(a_out[i]), 32'(v0 + 8'(i)));
    endtask

    typedef struct {
        logic       flush;
        logic       ready;
        logic       rd_en;
        logic       valid;
        logic [7:0] data;
        logic       busy;
    } vec_t;

    vec_t tv[9];

    initial begin
        int first_rd, last_rd, n_rd, first_vld, bad_hold, gaps, uf0, cyc;
        logic [7:0] exp_head;

        // flush pulse on row 0 with five words waiting in the FIFO
        tv[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        tv[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
        tv[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
        tv[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 1'b1};
        tv[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h02, 1'b1};
        tv[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 1'b1};
        tv[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h04, 1'b1};
        tv[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h05, 1'b1};
        tv[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

        rst = 1'b0; clr = 1'b1;
        a_wr = 1'b0; b_wr = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
        a_flush = 1'b0; b_flush = 1'b0; a_wdata = 8'h00; b_wdata = 8'h00;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_valid", 32'(a_valid), 0);
        chk("rst_rd_en", 32'(a_rd_en), 0);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_count", 32'(a_count), 0);
        chk("rst_data", 32'(a_data), 0);
`ifdef FIFO_RD_CHECKSUM_EN
        chk("rst_sum", 32'(a_sum), 0);
`endif

        // Partial fill waits for flush, then drains in order
        do_reset();
        write_a(5, 8'h01);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_rd_en", 32'(a_rd_en), 0);
            chk("idle_valid", 32'(a_valid), 0);
            chk("idle_busy", 32'(a_busy), 0);
            next_cycle();
        end
        for (int i = 0; i < 9; i++) begin
            a_flush = tv[i].flush;
            a_ready = tv[i].ready;
            @(negedge clk);
            chk("flush_rd_en", 32'(a_rd_en), 32'(tv[i].rd_en));
            chk("flush_valid", 32'(a_valid), 32'(tv[i].valid));
            chk("flush_busy", 32'(a_busy), 32'(tv[i].busy));
            if (tv[i].valid) chk("flush_data", 32'(a_data), 32'(tv[i].data));
            next_cycle();
        end
        chk("flush_count", 32'(a_count), 5);

        // Full FIFO, m_ready held high
        do_reset();
        uf0 = a_uf;
        a_ready = 1'b1;
        write_a(16, 8'h01);
        first_rd = -1; last_rd = -1; n_rd = 0; first_vld = -1;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (a_rd_en) begin
                if (first_rd < 0) first_rd = j;
                last_rd = j;
                n_rd++;
            end
            if (a_valid && first_vld < 0) first_vld = j;
            next_cycle();
        end
        chk("full_first_rd", 32'(first_rd), 1);
        chk("full_n_rd", 32'(n_rd), 16);
        chk("full_rd_span", 32'(last_rd - first_rd), 15);
        chk("full_first_valid", 32'(first_vld), 3);
        check_seq_a("full_seq", 16, 8'h01);
        @(negedge clk);
        chk("full_busy_end", 32'(a_busy), 0);
        chk("full_count", 32'(a_count), 16);
        chk("full_underflow", 32'(a_uf - uf0), 0);
`ifdef FIFO_RD_CHECKSUM_EN
        chk("full_sum", 32'(a_sum), 32'h88);
`endif
        next_cycle();

        // Full FIFO, m_ready held low, then released
        do_reset();
        a_ready = 1'b0;
        write_a(16, 8'h01);
        n_rd = 0; bad_hold = 0; first_vld = -1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (a_rd_en) n_rd++;
            if (a_valid && first_vld < 0) first_vld = j;
            if (first_vld >= 0 && (!a_valid || a_data != 8'h01)) bad_hold++;
            next_cycle();
        end
        chk("stall_n_rd", 32'(n_rd), 4);
        chk("stall_hold", 32'(bad_hold), 0);
        @(negedge clk);
        chk("stall_valid", 32'(a_valid), 1);
        chk("stall_data", 32'(a_data), 32'h01);
        next_cycle();
        a_ready = 1'b1;
        gaps = 0;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            if (!a_valid) gaps++;
            next_cycle();
        end
        chk("stall_gaps", 32'(gaps), 0);
        check_seq_a("stall_seq", 16, 8'h01);
        chk("stall_count", 32'(a_count), 16);

        // Alternating backpressure during a full drain
        do_reset();
        uf0 = a_uf;
        write_a(16, 8'h01);
        cyc = 0;
        while (a_out.size() < 16 && cyc < 100) begin
            a_ready = ((cyc & 1) == 0);
            next_cycle();
            cyc++;
        end
        a_ready = 1'b0;
        chk("toggle_timeout", 32'(cyc < 100), 1);
        check_seq_a("toggle_seq", 16, 8'h01);
        @(negedge clk);
        chk("toggle_count", 32'(a_count), 16);
        chk("toggle_underflow", 32'(a_uf - uf0), 0);
        next_cycle();

        // Auto-start: single word latency
        do_reset();
        b_ready = 1'b1;
        write_b(1, 8'h2A);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (j == 2) chk("auto_valid_early", 32'(b_valid), 0);
            if (j == 3) begin
                chk("auto_valid", 32'(b_valid), 1);
                chk("auto_data", 32'(b_data), 32'h2A);
            end
            next_cycle();
        end

        // Reset in the middle of a drain
        do_reset();
        uf0 = b_uf;
        b_ready = 1'b0;
        write_b(12, 8'h31);
        b_ready = 1'b1;
        cyc = 0;
        while (b_out.size() < 6 && cyc < 30) begin
            next_cycle();
            cyc++;
        end
        chk("mid_timeout", 32'(cyc < 30), 1);
        rst = 1'b0;
        b_ready = 1'b0;
        @(negedge clk);
        chk("mid_rd_en_gated", 32'(b_rd_en), 0);
        next_cycle();
        rst = 1'b1;
        exp_head = (b_q.size() != 0) ? b_q[0] : 8'h00;
        @(negedge clk);
        chk("mid_valid", 32'(b_valid), 0);
        chk("mid_count", 32'(b_count), 0);
        chk("mid_rd_en", 32'(b_rd_en), 0);
        next_cycle();
        b_ready = 1'b1;
        cyc = 0;
        while (b_out.size() < 3 && cyc < 20) begin
            next_cycle();
            cyc++;
        end
        chk("mid_resume_timeout", 32'(cyc < 20), 1);
        if (b_out.size() >= 3) begin
            chk("mid_head", 32'(b_out[0]), 32'(exp_head));
            chk("mid_next1", 32'(b_out[1]), 32'(exp_head + 8'd1));
            chk("mid_next2", 32'(b_out[2]), 32'(exp_head + 8'd2));
        end
        chk("mid_underflow", 32'(b_uf - uf0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
